// File: rtl/mrr_tx_frame_packer.sv
// Packs 12-bit I/Q samples into four 6-bit words with a 50% frame strobe for the AD9361 TX port.
// Optional underflow counter output enabled by defining MRR_TX_PACKER_UFLOW_CNT_EN.
//
// state | meaning
// IDLE  | no sample in flight; outputs parked at IDLE_WORD, frame low
// RUN   | emitting one word per clk, phase 0..3 selects the word
module mrr_tx_frame_packer #(
  parameter int         SWAP_IQ   = 0,
  parameter logic [5:0] IDLE_WORD = 6'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [11:0] s_i,
  input  logic [11:0] s_q,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        tx_frame,
  output logic [5:0]  tx_data,
  output logic        busy,
  output logic        underflow
`ifdef MRR_TX_PACKER_UFLOW_CNT_EN
  ,
  output logic [15:0] uflow_count
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [1:0]  phase;
  logic [1:0]  phase_nxt;
  logic [11:0] i_reg;
  logic [11:0] q_reg;
  logic        fill;
  logic        accept;

  // Word order within a sample: first-component MSBs, second MSBs, first LSBs, second LSBs.
  function automatic logic [5:0] word_sel(input logic [1:0] ph,
                                          input logic [11:0] wi,
                                          input logic [11:0] wq);
    logic [11:0] first;
    logic [11:0] second;
    logic [5:0]  w;
    first  = (SWAP_IQ != 0) ? wq : wi;
    second = (SWAP_IQ != 0) ? wi : wq;
    case (ph)
      2'd0:    w = first[11:6];
      2'd1:    w = second[11:6];
      2'd2:    w = first[5:0];
      default: w = second[5:0];
    endcase
    return w;
  endfunction

  assign s_ready   = !rst && enable && ((state == ST_IDLE) || (phase == 2'd3));
  assign accept    = s_ready && s_valid;
  assign phase_nxt = phase + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase     <= 2'd0;
      fill      <= 1'b0;
      i_reg     <= '0;
      q_reg     <= '0;
      tx_frame  <= 1'b0;
      tx_data   <= IDLE_WORD;
      busy      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      underflow <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_RUN;
            phase    <= 2'd0;
            fill     <= 1'b0;
            i_reg    <= s_i;
            q_reg    <= s_q;
            tx_frame <= 1'b1;
            tx_data  <= word_sel(2'd0, s_i, s_q);
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (phase != 2'd3) begin
            // mid-sample: enable is ignored so a sample is never truncated
            phase    <= phase_nxt;
            tx_frame <= (phase_nxt == 2'd1);
            tx_data  <= fill ? IDLE_WORD : word_sel(phase_nxt, i_reg, q_reg);
          end else if (!enable) begin
            state    <= ST_IDLE;
            phase    <= 2'd0;
            fill     <= 1'b0;
            tx_frame <= 1'b0;
            tx_data  <= IDLE_WORD;
            busy     <= 1'b0;
          end else if (s_valid) begin
            phase    <= 2'd0;
            fill     <= 1'b0;
            i_reg    <= s_i;
            q_reg    <= s_q;
            tx_frame <= 1'b1;
            tx_data  <= word_sel(2'd0, s_i, s_q);
          end else begin
            // starved: keep the frame cadence alive with a fill slot
            phase     <= 2'd0;
            fill      <= 1'b1;
            tx_frame  <= 1'b1;
            tx_data   <= IDLE_WORD;
            underflow <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          phase <= 2'd0;
        end
      endcase
    end
  end

`ifdef MRR_TX_PACKER_UFLOW_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      uflow_count <= '0;
    end else if (underflow && (uflow_count != 16'hFFFF)) begin
      uflow_count <= uflow_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mrr_tx_frame_packer.sv
// Bench for mrr_tx_frame_packer: a slot-queue model checks two instances (plain and IQ-swapped) every cycle.
module tb_mrr_tx_frame_packer;

  logic        clk = 1'b0;
  logic        rst, enable, s_valid;
  logic [11:0] s_i, s_q;
  logic        rdy0, frm0, busy0, uf0;
  logic        rdy1, frm1, busy1, uf1;
  logic [5:0]  dat0, dat1;
`ifdef MRR_TX_PACKER_UFLOW_CNT_EN
  logic [15:0] ucnt0, ucnt1;
`endif

  localparam logic [5:0] IDW0 = 6'h00;
  localparam logic [5:0] IDW1 = 6'h15;

  always #5 clk = ~clk;

  mrr_tx_frame_packer u_dut0 (
    .clk(clk), .rst(rst), .enable(enable), .s_i(s_i), .s_q(s_q), .s_valid(s_valid),
    .s_ready(rdy0), .tx_frame(frm0), .tx_data(dat0), .busy(busy0), .underflow(uf0)
`ifdef MRR_TX_PACKER_UFLOW_CNT_EN
    , .uflow_count(ucnt0)
`endif
  );

  mrr_tx_frame_packer #(.SWAP_IQ(1), .IDLE_WORD(IDW1)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable), .s_i(s_i), .s_q(s_q), .s_valid(s_valid),
    .s_ready(rdy1), .tx_frame(frm1), .tx_data(dat1), .busy(busy1), .underflow(uf1)
`ifdef MRR_TX_PACKER_UFLOW_CNT_EN
    , .uflow_count(ucnt1)
`endif
  );

  typedef struct {
    logic        fill;
    logic [11:0] i;
    logic [11:0] q;
    int          ph;
  } slot_t;

  int    n_assert = 0;
  int    n_fail   = 0;
  bit    chk_en   = 0;
  slot_t mq[$];
  slot_t cur;
  bit    cur_run  = 0;
  int    m_uflows = 0;
  int    uf_seen  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [5:0] exp_word(input int swap, input slot_t s, input logic [5:0] idw);
    logic [11:0] a, b, v;
    if (s.fill) return idw;
    a = (swap != 0) ? s.q : s.i;
    b = (swap != 0) ? s.i : s.q;
    case (s.ph)
      0:       v = a / 64;
      1:       v = b / 64;
      2:       v = a % 64;
      default: v = b % 64;
    endcase
    return v[5:0];
  endfunction

  task automatic push_slot(input logic f, input logic [11:0] i, input logic [11:0] q);
    slot_t s;
    for (int p = 0; p < 4; p++) begin
      s.fill = f; s.i = i; s.q = q; s.ph = p;
      mq.push_back(s);
    end
  endtask

  // Stream model: each accepted sample or fill slot contributes four words to a queue.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      cur_run = 0;
    end else if (mq.size() > 0) begin
      cur = mq.pop_front();
    end else if (enable && s_valid) begin
      push_slot(1'b0, s_i, s_q);
      cur = mq.pop_front();
      cur_run = 1;
    end else if (enable && cur_run) begin
      push_slot(1'b1, 12'h000, 12'h000);
      m_uflows++;
      cur = mq.pop_front();
    end else begin
      cur_run = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic er, ef, eb, eu;
      logic [5:0] ed0, ed1;
      er = !rst && enable && (mq.size() == 0);
      if (cur_run) begin
        ef = (cur.ph < 2); eb = 1'b1; eu = cur.fill && (cur.ph == 0);
        ed0 = exp_word(0, cur, IDW0);
        ed1 = exp_word(1, cur, IDW1);
      end else begin
        ef = 1'b0; eb = 1'b0; eu = 1'b0; ed0 = IDW0; ed1 = IDW1;
      end
      chk("s_ready0", {15'd0, rdy0}, {15'd0, er});
      chk("s_ready1", {15'd0, rdy1}, {15'd0, er});
      chk("tx_frame0", {15'd0, frm0}, {15'd0, ef});
      chk("tx_frame1", {15'd0, frm1}, {15'd0, ef});
      chk("tx_data0", {10'd0, dat0}, {10'd0, ed0});
      chk("tx_data1", {10'd0, dat1}, {10'd0, ed1});
      chk("busy0", {15'd0, busy0}, {15'd0, eb});
      chk("busy1", {15'd0, busy1}, {15'd0, eb});
      chk("underflow0", {15'd0, uf0}, {15'd0, eu});
      chk("underflow1", {15'd0, uf1}, {15'd0, eu});
      if (uf0 === 1'b1) uf_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] lit0 [4];
  logic [5:0] lit1 [4];
  logic       litf [4];

  initial begin
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_i = '0; s_q = '0;
    tick();
    chk_en = 1;
    tick();

    // single sample, literal word sequence for both orderings
    rst = 1'b0; enable = 1'b1; s_valid = 1'b1; s_i = 12'hABC; s_q = 12'h123;
    lit0[0] = 6'h2A; lit0[1] = 6'h04; lit0[2] = 6'h3C; lit0[3] = 6'h23;
    lit1[0] = 6'h04; lit1[1] = 6'h2A; lit1[2] = 6'h23; lit1[3] = 6'h3C;
    litf[0] = 1'b1;  litf[1] = 1'b1;  litf[2] = 1'b0;  litf[3] = 1'b0;
    tick();
    enable = 1'b0; s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lit_word0", {10'd0, dat0}, {10'd0, lit0[k]});
      chk("lit_word1", {10'd0, dat1}, {10'd0, lit1[k]});
      chk("lit_frame", {15'd0, frm0}, {15'd0, litf[k]});
      tick();
    end
    @(negedge clk);
    chk("lit_idle_frame", {15'd0, frm0}, 16'd0);
    chk("lit_idle_data1", {10'd0, dat1}, 16'h0015);
    chk("lit_idle_busy", {15'd0, busy0}, 16'd0);

    // SWAP_IQ literal: I=FFF Q=000 on the swapped instance
    tick();
    enable = 1'b1; s_valid = 1'b1; s_i = 12'hFFF; s_q = 12'h000;
    tick();
    enable = 1'b0; s_valid = 1'b0;
    lit1[0] = 6'h00; lit1[1] = 6'h3F; lit1[2] = 6'h00; lit1[3] = 6'h3F;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lit_swap", {10'd0, dat1}, {10'd0, lit1[k]});
      tick();
    end

    // eight back-to-back samples
    uf_seen = 0;
    enable = 1'b1; s_valid = 1'b1;
    for (int n = 0; n < 8; n++) begin
      s_i = 12'(12'h0A5 + n * 12'h111);
      s_q = 12'(12'hF0F - n * 12'h0C3);
      tick();
      if (n == 7) begin enable = 1'b0; s_valid = 1'b0; end
      tick(); tick(); tick();
    end
    tick(); tick();
    chk("b2b_no_underflow", uf_seen[15:0], 16'd0);

    // one starved slot
    uf_seen = 0;
    enable = 1'b1; s_valid = 1'b1; s_i = 12'h5A3; s_q = 12'h3C7;
    tick();
    s_valid = 1'b0;
    tick(); tick(); tick(); tick();
    @(negedge clk);
    chk("fill_uf", {15'd0, uf0}, 16'd1);
    chk("fill_frame", {15'd0, frm0}, 16'd1);
    chk("fill_data1", {10'd0, dat1}, 16'h0015);
    s_valid = 1'b1; s_i = 12'h7E1; s_q = 12'h81F;
    tick(); tick(); tick(); tick();
    enable = 1'b0; s_valid = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("fill_uf_count", uf_seen[15:0], 16'd1);

    // enable dropped at phase 1 still completes the sample
    enable = 1'b1; s_valid = 1'b1; s_i = 12'h246; s_q = 12'h9BD;
    tick();
    s_valid = 1'b0;
    tick();
    enable = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("en_drop_ph3_frame", {15'd0, frm0}, 16'd0);
    chk("en_drop_ph3_busy", {15'd0, busy0}, 16'd1);
    tick();
    @(negedge clk);
    chk("en_drop_idle_busy", {15'd0, busy0}, 16'd0);

    // reset at phase 2, inputs still requesting
    enable = 1'b1; s_valid = 1'b1; s_i = 12'hC3A; s_q = 12'h5F0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_frame", {15'd0, frm0}, 16'd0);
    chk("rst_data1", {10'd0, dat1}, 16'h0015);
    chk("rst_busy", {15'd0, busy0}, 16'd0);
    chk("rst_ready", {15'd0, rdy0}, 16'd0);
    tick();
    rst = 1'b0;
    tick();
    enable = 1'b0; s_valid = 1'b0;
    tick(); tick(); tick(); tick(); tick();

`ifdef MRR_TX_PACKER_UFLOW_CNT_EN
    chk("uflow_count0", ucnt0, 16'(m_uflows));
    chk("uflow_count1", ucnt1, 16'(m_uflows));
`endif

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
